// File: rtl/instruction_decode_pkg.sv
// Shared processor definitions: opcodes and instruction field positions.
// Used by instruction_decode (optional bypass: INSTRUCTION_DECODE_FWD_EN).
package instruction_decode_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_RSV = 2'b10,
    OP_JMP = 2'b11
  } op_e;

  localparam int INSN_W  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int TGT_LSB = 0;
  localparam int REG_AW  = 3;
  localparam int TGT_W   = 6;
  localparam int NREGS   = 8;

  function automatic op_e insn_op(input logic [INSN_W-1:0] insn);
    return op_e'(insn[OP_LSB +: 2]);
  endfunction

  function automatic logic has_regs(input op_e op);
    return (op == OP_MOV) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 8-entry register file: one write port, two combinational read ports.
// Entries reset asynchronously to RST_VAL.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int              DATA_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '{default: RST_VAL};
    else       mem_q <= mem_d;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: valid/ready skid-free output register plus register file.
// Define INSTRUCTION_DECODE_FWD_EN to bypass write-back data into reads.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [INSN_W-1:0] instruction_code,
  output logic              id_ready,
  input  logic              ex_ready,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [1:0]        id_op,
  output logic [REG_AW-1:0] id_rd,
  output logic [DATA_W-1:0] id_rd_data,
  output logic [DATA_W-1:0] id_rs_data,
  output logic              id_jump,
  output logic [TGT_W-1:0]  id_target
);

  op_e               op;
  logic [REG_AW-1:0] rd_idx, rs_idx;
  logic [DATA_W-1:0] rf_rd, rf_rs;
  logic [DATA_W-1:0] rd_fwd, rs_fwd;
  logic              accept;

  logic              valid_q, valid_d;
  op_e               op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic              jump_q, jump_d;
  logic [TGT_W-1:0]  target_q, target_d;

  assign op     = insn_op(instruction_code);
  assign rd_idx = instruction_code[RD_LSB +: REG_AW];
  assign rs_idx = instruction_code[RS_LSB +: REG_AW];

  register_file #(
    .DATA_W  (DATA_W),
    .RST_VAL (REG_RST_VAL)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rd_idx),
    .rdata_a (rf_rd),
    .raddr_b (rs_idx),
    .rdata_b (rf_rs)
  );

`ifdef INSTRUCTION_DECODE_FWD_EN
  assign rd_fwd = (wb_en && wb_addr == rd_idx) ? wb_data : rf_rd;
  assign rs_fwd = (wb_en && wb_addr == rs_idx) ? wb_data : rf_rs;
`else
  assign rd_fwd = rf_rd;
  assign rs_fwd = rf_rs;
`endif

  assign id_ready = !valid_q || ex_ready;
  assign accept   = if_valid && id_ready;

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
    rs_data_d = rs_data_q;
    jump_d    = jump_q;
    target_d  = target_q;
    if (valid_q && ex_ready) valid_d = 1'b0;
    // Reserved ops fall through: consumed, register only vacated.
    if (accept) begin
      unique case (1'b1)
        has_regs(op): begin
          valid_d   = 1'b1;
          op_d      = op;
          rd_d      = rd_idx;
          rd_data_d = rd_fwd;
          rs_data_d = rs_fwd;
          jump_d    = 1'b0;
          target_d  = '0;
        end
        (op == OP_JMP): begin
          valid_d   = 1'b1;
          op_d      = op;
          rd_d      = '0;
          rd_data_d = '0;
          rs_data_d = '0;
          jump_d    = 1'b1;
          target_d  = instruction_code[TGT_LSB +: TGT_W];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      op_q      <= OP_MOV;
      rd_q      <= '0;
      rd_data_q <= '0;
      rs_data_q <= '0;
      jump_q    <= 1'b0;
      target_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
      rs_data_q <= rs_data_d;
      jump_q    <= jump_d;
      target_q  <= target_d;
    end
  end

  assign id_valid   = valid_q;
  assign id_op      = op_q;
  assign id_rd      = rd_q;
  assign id_rd_data = rd_data_q;
  assign id_rs_data = rs_data_q;
  assign id_jump    = jump_q;
  assign id_target  = target_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with an expected-output queue.
// Honours INSTRUCTION_DECODE_FWD_EN for the bypass expectation.
module tb_instruction_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_valid;
  logic [7:0] instruction_code;
  logic       id_ready;
  logic       ex_ready;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       id_valid;
  logic [1:0] id_op;
  logic [2:0] id_rd;
  logic [7:0] id_rd_data;
  logic [7:0] id_rs_data;
  logic       id_jump;
  logic [5:0] id_target;

  typedef struct {
    logic [1:0] op;
    logic [2:0] rd;
    logic [7:0] rd_data;
    logic [7:0] rs_data;
    logic       jump;
    logic [5:0] target;
  } exp_t;

  exp_t       q[$];
  logic [7:0] rf[8];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .instruction_code (instruction_code),
    .id_ready         (id_ready),
    .ex_ready         (ex_ready),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .id_valid         (id_valid),
    .id_op            (id_op),
    .id_rd            (id_rd),
    .id_rd_data       (id_rd_data),
    .id_rs_data       (id_rs_data),
    .id_jump          (id_jump),
    .id_target        (id_target)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rf_model_reset();
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  endtask

  // One cycle: drive after negedge, check, update model, wait for edge.
  task automatic cyc(input logic v, input logic [7:0] ins,
                     input logic exr, input logic we,
                     input logic [2:0] wa, input logic [7:0] wd);
    exp_t       e;
    logic       mvalid;
    logic       acc;
    logic [2:0] rdi, rsi;
    @(negedge clk);
    if_valid = v;
    instruction_code = ins;
    ex_ready = exr;
    wb_en = we;
    wb_addr = wa;
    wb_data = wd;
    #1;
    mvalid = (q.size() != 0);
    chk("id_valid", {31'b0, id_valid}, {31'b0, mvalid});
    chk("id_ready", {31'b0, id_ready}, {31'b0, !mvalid || exr});
    if (mvalid) begin
      e = q[0];
      chk("id_op", {30'b0, id_op}, {30'b0, e.op});
      chk("id_jump", {31'b0, id_jump}, {31'b0, e.jump});
      chk("id_rd_data", {24'b0, id_rd_data}, {24'b0, e.rd_data});
      chk("id_rs_data", {24'b0, id_rs_data}, {24'b0, e.rs_data});
      if (e.jump)
        chk("id_target", {26'b0, id_target}, {26'b0, e.target});
      else
        chk("id_rd", {29'b0, id_rd}, {29'b0, e.rd});
      if (exr) void'(q.pop_front());
    end
    acc = v && (!mvalid || exr);
    rdi = ins[5:3];
    rsi = ins[2:0];
    if (acc && ins[7:6] != 2'b10) begin
      e.op = ins[7:6];
      e.jump = (ins[7:6] == 2'b11);
      e.target = ins[5:0];
      e.rd = rdi;
      if (e.jump) begin
        e.rd_data = 8'h00;
        e.rs_data = 8'h00;
      end else begin
        e.rd_data = rf[rdi];
        e.rs_data = rf[rsi];
`ifdef INSTRUCTION_DECODE_FWD_EN
        if (we && wa == rdi) e.rd_data = wd;
        if (we && wa == rsi) e.rs_data = wd;
`endif
      end
      q.push_back(e);
    end
    if (we) rf[wa] = wd;
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    if_valid = 1'b0;
    instruction_code = 8'h00;
    ex_ready = 1'b1;
    wb_en = 1'b0;
    wb_addr = 3'd0;
    wb_data = 8'h00;
    rf_model_reset();
    #12;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_ready", {31'b0, id_ready}, 32'd1);
    chk("rst_id_rs_data", {24'b0, id_rs_data}, 32'd0);
    chk("rst_id_jump", {31'b0, id_jump}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    cyc(0, 8'h00, 1, 1, 3'd2, 8'h05);
    cyc(0, 8'h00, 1, 1, 3'd3, 8'h07);
    cyc(1, 8'b01_010_011, 1, 0, 3'd0, 8'h00);
    cyc(0, 8'h00, 1, 0, 3'd0, 8'h00);

    cyc(1, 8'hC5, 1, 0, 3'd0, 8'h00);
    cyc(0, 8'h00, 1, 0, 3'd0, 8'h00);

    // Stall three cycles with a pending instruction and a write-back.
    cyc(1, 8'b00_010_011, 1, 0, 3'd0, 8'h00);
    cyc(1, 8'b01_011_101, 0, 1, 3'd5, 8'h33);
    cyc(1, 8'b01_011_101, 0, 0, 3'd0, 8'h00);
    cyc(1, 8'b01_011_101, 0, 0, 3'd0, 8'h00);
    cyc(1, 8'b01_011_101, 1, 0, 3'd0, 8'h00);
    cyc(0, 8'h00, 1, 0, 3'd0, 8'h00);

    cyc(1, 8'h80, 1, 0, 3'd0, 8'h00);
    cyc(0, 8'h00, 1, 0, 3'd0, 8'h00);
    chk("rsv_empty", q.size(), 32'd0);

    cyc(1, 8'b00_001_011, 1, 1, 3'd3, 8'hAA);
    cyc(1, 8'b00_100_011, 1, 0, 3'd0, 8'h00);
    cyc(0, 8'h00, 1, 0, 3'd0, 8'h00);

    // Reset in the middle of a stall.
    cyc(1, 8'b01_110_101, 1, 0, 3'd0, 8'h00);
    cyc(1, 8'b00_000_001, 0, 0, 3'd0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("midrst_id_ready", {31'b0, id_ready}, 32'd1);
    chk("midrst_id_rd_data", {24'b0, id_rd_data}, 32'd0);
    q.delete();
    rf_model_reset();
    if_valid = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, id_ready}, 32'd1);

    cyc(1, 8'b00_000_001, 1, 0, 3'd0, 8'h00);
    cyc(1, 8'b00_010_011, 1, 0, 3'd0, 8'h00);
    cyc(1, 8'b00_100_101, 1, 0, 3'd0, 8'h00);
    cyc(1, 8'b00_110_111, 1, 0, 3'd0, 8'h00);
    cyc(0, 8'h00, 1, 0, 3'd0, 8'h00);
    cyc(0, 8'h00, 1, 0, 3'd0, 8'h00);
    chk("final_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
